// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever
// surrounds it (fetch unit, load/store unit and the memory together).
interface mem_port_arbiter_if;
   // instruction fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   // data load/store port
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   // memory pins
   logic        mem_write_enable;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;
   // status
   logic        busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_read_data,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_write_enable, mem_funct3, mem_write_address, mem_write_data,
             mem_read_address, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_read_data,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_write_enable, mem_funct3, mem_write_address, mem_write_data,
             mem_read_address, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port. Data port D has fixed
// priority; fetch port I wins a contention once D has beaten it MAX_STARVE
// times in a row. One transaction in flight; every output is registered.
module mem_port_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int MAX_STARVE   = 4
) (
   input logic                 clk,
   input logic                 reset,
   mem_port_arbiter_if.slave   bus
);

   localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
   localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   // control state
   state_t          r_state,    w_state_next;
   logic [CW-1:0]   r_cnt,      w_cnt_next;
   logic [SW-1:0]   r_starve,   w_starve_next;
   logic            r_owner_d,  w_owner_d_next;
   logic            r_is_store, w_is_store_next;

   // registered outputs
   logic            r_if_gnt,   w_if_gnt_next;
   logic            r_if_rvalid, w_if_rvalid_next;
   logic [31:0]     r_if_rdata, w_if_rdata_next;
   logic            r_d_gnt,    w_d_gnt_next;
   logic            r_d_rvalid, w_d_rvalid_next;
   logic [31:0]     r_d_rdata,  w_d_rdata_next;
   logic            r_mem_we,   w_mem_we_next;
   logic [2:0]      r_mem_f3,   w_mem_f3_next;
   logic [31:0]     r_mem_waddr, w_mem_waddr_next;
   logic [31:0]     r_mem_wdata, w_mem_wdata_next;
   logic [31:0]     r_mem_raddr, w_mem_raddr_next;
   logic            r_busy,     w_busy_next;

   // arbitration: RESP doubles as an IDLE sample point so back-to-back
   // transactions lose no cycle
   logic w_sample, w_starved, w_grant_i, w_grant_d, w_capture;
   assign w_sample  = (r_state == S_IDLE) || (r_state == S_RESP);
   assign w_starved = (r_starve == SW'(MAX_STARVE));
   assign w_grant_i = w_sample && bus.if_req && (!bus.d_req || w_starved);
   assign w_grant_d = w_sample && bus.d_req && !w_grant_i;
   assign w_capture = (r_state == S_WAIT) && (r_cnt == CW'(1));

   // state register plus every registered output; reset is asynchronous
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_owner_d   <= 1'b0;
         r_is_store  <= 1'b0;
         r_if_gnt    <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_d_gnt     <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= '0;
         r_mem_we    <= 1'b0;
         r_mem_f3    <= F3_WORD;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_mem_raddr <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_starve    <= w_starve_next;
         r_owner_d   <= w_owner_d_next;
         r_is_store  <= w_is_store_next;
         r_if_gnt    <= w_if_gnt_next;
         r_if_rvalid <= w_if_rvalid_next;
         r_if_rdata  <= w_if_rdata_next;
         r_d_gnt     <= w_d_gnt_next;
         r_d_rvalid  <= w_d_rvalid_next;
         r_d_rdata   <= w_d_rdata_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_f3    <= w_mem_f3_next;
         r_mem_waddr <= w_mem_waddr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_mem_raddr <= w_mem_raddr_next;
         r_busy      <= w_busy_next;
      end
   end

   // next state, latency counter, transaction owner and starvation count
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_starve_next   = r_starve;
      w_owner_d_next  = r_owner_d;
      w_is_store_next = r_is_store;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (w_grant_i || w_grant_d) begin
               w_state_next    = S_ACCESS;
               w_owner_d_next  = w_grant_d;
               w_is_store_next = w_grant_d && bus.d_we;
            end else begin
               w_state_next    = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (r_is_store) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_WAIT;
               w_cnt_next   = CW'(READ_LATENCY);
            end
         end
         S_WAIT: begin
            if (w_capture) begin
               w_state_next = S_RESP;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt - CW'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      // fetch grant clears the count; a D win over a waiting fetch bumps it
      if (w_grant_i) begin
         w_starve_next = '0;
      end else if (w_grant_d && bus.if_req && !w_starved) begin
         w_starve_next = r_starve + SW'(1);
      end
   end

   // next values of the registered outputs
   always_comb begin
      w_if_gnt_next    = 1'b0;
      w_d_gnt_next     = 1'b0;
      w_if_rvalid_next = 1'b0;
      w_d_rvalid_next  = 1'b0;
      w_if_rdata_next  = r_if_rdata;
      w_d_rdata_next   = r_d_rdata;
      w_mem_we_next    = r_mem_we;
      w_mem_f3_next    = r_mem_f3;
      w_mem_waddr_next = r_mem_waddr;
      w_mem_wdata_next = r_mem_wdata;
      w_mem_raddr_next = r_mem_raddr;
      w_busy_next      = (w_state_next != S_IDLE);

      if (w_grant_i) begin
         w_if_gnt_next    = 1'b1;
         w_mem_raddr_next = bus.if_addr;
         w_mem_f3_next    = F3_WORD;
         w_mem_we_next    = 1'b0;
      end else if (w_grant_d) begin
         w_d_gnt_next     = 1'b1;
         w_mem_f3_next    = bus.d_funct3;
         if (bus.d_we) begin
            w_mem_we_next    = 1'b1;
            w_mem_waddr_next = bus.d_addr;
            w_mem_wdata_next = bus.d_wdata;
         end else begin
            w_mem_we_next    = 1'b0;
            w_mem_raddr_next = bus.d_addr;
         end
      end

      // a store occupies exactly one ACCESS cycle, then the write pins park
      if (r_state == S_ACCESS && r_is_store) begin
         w_mem_we_next    = 1'b0;
         w_mem_waddr_next = '0;
         w_mem_f3_next    = F3_WORD;
      end

      // read data is captured on the last WAIT cycle and returned in RESP
      if (w_capture) begin
         if (r_owner_d) begin
            w_d_rvalid_next  = 1'b1;
            w_d_rdata_next   = bus.mem_read_data;
         end else begin
            w_if_rvalid_next = 1'b1;
            w_if_rdata_next  = bus.mem_read_data;
         end
      end
   end

   assign bus.if_gnt            = r_if_gnt;
   assign bus.if_rvalid         = r_if_rvalid;
   assign bus.if_rdata          = r_if_rdata;
   assign bus.d_gnt             = r_d_gnt;
   assign bus.d_rvalid          = r_d_rvalid;
   assign bus.d_rdata           = r_d_rdata;
   assign bus.mem_write_enable  = r_mem_we;
   assign bus.mem_funct3        = r_mem_f3;
   assign bus.mem_write_address = r_mem_waddr;
   assign bus.mem_write_data    = r_mem_wdata;
   assign bus.mem_read_address  = r_mem_raddr;
   assign bus.busy              = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LATENCY=1 and
// one with READ_LATENCY=3, each backed by a small pipelined memory model.
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;

   mem_port_arbiter_if b1();
   mem_port_arbiter_if b3();

   mem_port_arbiter #(.READ_LATENCY(1), .MAX_STARVE(4)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   mem_port_arbiter #(.READ_LATENCY(3), .MAX_STARVE(4)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (b3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // word-addressed memory shared by both models
   logic [31:0] mem [0:255];
   logic [31:0] p1;
   logic [31:0] p3a, p3b, p3c;

   // one-stage read pipe for the latency-1 instance
   always @(posedge clk) p1 <= mem[b1.mem_read_address[9:2]];
   // three-stage read pipe for the latency-3 instance
   always @(posedge clk) begin
      p3a <= mem[b3.mem_read_address[9:2]];
      p3b <= p3a;
      p3c <= p3b;
   end
   assign b1.mem_read_data = p1;
   assign b3.mem_read_data = p3c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // returns 1 for a fetch grant, 2 for a data grant, 0 on timeout
   task automatic wait_gnt(output int who);
      who = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b1.if_gnt) begin who = 1; break; end
         if (b1.d_gnt)  begin who = 2; break; end
      end
   endtask

   task automatic wait_idle(output int ok);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!b1.busy) begin ok = 1; break; end
      end
   endtask

   initial begin
      int who;
      int ok;
      int exp_seq [6];
      exp_seq = '{2, 2, 2, 2, 1, 2};
      n_total = 0;
      n_pass  = 0;
      for (int k = 0; k < 256; k++) mem[k] = 32'hDEAD_0000 | k;
      mem[4]  = 32'h0050_0093;   // 0x10
      mem[8]  = 32'h1111_2222;   // 0x20
      mem[16] = 32'hCAFE_F00D;   // 0x40

      b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0;
      b1.d_funct3 = 3'b010; b1.d_addr = 0; b1.d_wdata = 0;
      b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0;
      b3.d_funct3 = 3'b010; b3.d_addr = 0; b3.d_wdata = 0;
      reset = 1'b1;

      // reset values
      tick(); tick();
      chk("rst_busy", 32'(b1.busy), 0);
      chk("rst_if_gnt", 32'(b1.if_gnt), 0);
      chk("rst_we", 32'(b1.mem_write_enable), 0);
      chk("rst_funct3", 32'(b1.mem_funct3), 32'h2);
      chk("rst_raddr", b1.mem_read_address, 0);
      chk("rst_if_rdata", b1.if_rdata, 0);
      reset = 1'b0;
      tick();

      // single fetch
      b1.if_req = 1; b1.if_addr = 32'h10;
      tick();   // N+1
      b1.if_req = 0;
      chk("f_if_gnt", 32'(b1.if_gnt), 1);
      chk("f_d_gnt", 32'(b1.d_gnt), 0);
      chk("f_raddr", b1.mem_read_address, 32'h10);
      chk("f_funct3", 32'(b1.mem_funct3), 32'h2);
      chk("f_busy", 32'(b1.busy), 1);
      tick();   // N+2
      chk("f_gnt_pulse", 32'(b1.if_gnt), 0);
      chk("f_rvalid_early", 32'(b1.if_rvalid), 0);
      tick();   // N+3
      chk("f_rvalid", 32'(b1.if_rvalid), 1);
      chk("f_rdata", b1.if_rdata, 32'h0050_0093);
      tick();   // N+4
      chk("f_rvalid_pulse", 32'(b1.if_rvalid), 0);
      chk("f_idle", 32'(b1.busy), 0);
      chk("f_raddr_hold", b1.mem_read_address, 32'h10);

      // store
      b1.d_req = 1; b1.d_we = 1; b1.d_funct3 = 3'b000;
      b1.d_addr = 32'h2000; b1.d_wdata = 32'hAB;
      tick();   // N+1
      b1.d_req = 0;
      chk("s_d_gnt", 32'(b1.d_gnt), 1);
      chk("s_we", 32'(b1.mem_write_enable), 1);
      chk("s_waddr", b1.mem_write_address, 32'h2000);
      chk("s_wdata", b1.mem_write_data, 32'hAB);
      chk("s_funct3", 32'(b1.mem_funct3), 0);
      tick();   // N+2
      chk("s_we_off", 32'(b1.mem_write_enable), 0);
      chk("s_gnt_off", 32'(b1.d_gnt), 0);
      chk("s_waddr_clr", b1.mem_write_address, 0);
      chk("s_funct3_park", 32'(b1.mem_funct3), 32'h2);
      chk("s_busy", 32'(b1.busy), 0);
      tick();   // N+3
      chk("s_no_rvalid", 32'(b1.d_rvalid), 0);

      // contention: D load wins, fetch sampled in RESP
      b1.if_req = 1; b1.if_addr = 32'h20;
      b1.d_req = 1; b1.d_we = 0; b1.d_funct3 = 3'b010; b1.d_addr = 32'h40;
      tick();   // N+1
      b1.d_req = 0;
      chk("c_d_gnt", 32'(b1.d_gnt), 1);
      chk("c_if_gnt_lose", 32'(b1.if_gnt), 0);
      chk("c_raddr", b1.mem_read_address, 32'h40);
      tick();   // N+2
      tick();   // N+3
      chk("c_d_rvalid", 32'(b1.d_rvalid), 1);
      chk("c_d_rdata", b1.d_rdata, 32'hCAFE_F00D);
      chk("c_if_rvalid_none", 32'(b1.if_rvalid), 0);
      tick();   // N+4
      b1.if_req = 0;
      chk("c_if_gnt", 32'(b1.if_gnt), 1);
      chk("c_raddr_i", b1.mem_read_address, 32'h20);
      tick();   // N+5
      tick();   // N+6
      chk("c_if_rvalid", 32'(b1.if_rvalid), 1);
      chk("c_if_rdata", b1.if_rdata, 32'h1111_2222);
      chk("c_d_rdata_hold", b1.d_rdata, 32'hCAFE_F00D);

      // starvation: both held, D loads back-to-back
      b1.if_req = 1; b1.d_req = 1;
      for (int k = 0; k < 6; k++) begin
         wait_gnt(who);
         chk($sformatf("starve_g%0d", k), 32'(who), 32'(exp_seq[k]));
      end
      b1.if_req = 0; b1.d_req = 0;
      wait_idle(ok);
      chk("starve_idle", 32'(ok), 1);

      // reset during a store's ACCESS cycle drops the write strobe at once
      b1.d_req = 1; b1.d_we = 1; b1.d_funct3 = 3'b001;
      b1.d_addr = 32'h3000; b1.d_wdata = 32'h55;
      tick();
      b1.d_req = 0; b1.d_we = 0;
      chk("rs_we_before", 32'(b1.mem_write_enable), 1);
      reset = 1'b1;
      #1;
      chk("rs_we_async", 32'(b1.mem_write_enable), 0);
      chk("rs_gnt", 32'(b1.d_gnt), 0);
      chk("rs_waddr", b1.mem_write_address, 0);
      tick();
      reset = 1'b0;
      tick();

      // reset during WAIT of a load
      b1.d_req = 1; b1.d_funct3 = 3'b010; b1.d_addr = 32'h40;
      tick();   // ACCESS
      b1.d_req = 0;
      tick();   // WAIT
      chk("rl_busy_before", 32'(b1.busy), 1);
      reset = 1'b1;
      #1;
      chk("rl_busy", 32'(b1.busy), 0);
      chk("rl_d_rvalid", 32'(b1.d_rvalid), 0);
      chk("rl_d_rdata", b1.d_rdata, 0);
      chk("rl_raddr", b1.mem_read_address, 0);
      tick();
      chk("rl_no_rvalid", 32'(b1.d_rvalid), 0);
      reset = 1'b0;
      tick();
      chk("rl_still_idle", 32'(b1.d_rvalid | b1.busy), 0);
      b1.if_req = 1; b1.if_addr = 32'h10;
      tick();
      b1.if_req = 0;
      chk("rl_f_gnt", 32'(b1.if_gnt), 1);
      tick();
      tick();
      chk("rl_f_rvalid", 32'(b1.if_rvalid), 1);
      chk("rl_f_rdata", b1.if_rdata, 32'h0050_0093);

      // READ_LATENCY = 3 instance
      b3.if_req = 1; b3.if_addr = 32'h10;
      tick();   // N+1
      b3.if_req = 0;
      chk("l3_gnt", 32'(b3.if_gnt), 1);
      chk("l3_raddr", b3.mem_read_address, 32'h10);
      tick(); tick(); tick();   // N+4
      chk("l3_rvalid_early", 32'(b3.if_rvalid), 0);
      tick();   // N+5
      chk("l3_rvalid", 32'(b3.if_rvalid), 1);
      chk("l3_rdata", b3.if_rdata, 32'h0050_0093);
      tick();
      chk("l3_idle", 32'(b3.busy | b3.if_rvalid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (port I, word reads only) and data load/store (port D).
- Sits between the core sequencer and the memory; drives the memory's write_mem / funct3 / write_address / write_data / read_address pins and returns read data.
- Fixed priority to D, with a starvation guard for I; one transaction in flight at a time.

Parameters:
- READ_LATENCY, 1, cycles from memory capturing read_address to valid read_data (≥1).
- MAX_STARVE, 4, consecutive contended D wins after which I must win the next contention (≥1).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RV32I width/sign code, passed to memory.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  one-cycle pulse: data access accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only).
- d_rdata  out  32  load data, raw from memory.
- mem_write_enable  out  1  memory write strobe.
- mem_funct3  out  3  memory access width.
- mem_write_address  out  32  memory write address.
- mem_write_data  out  32  memory write data.
- mem_read_address  out  32  memory read address.
- mem_read_data  in  32  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs registered.
- Reset values:
  - gnt, rvalid, mem_write_enable, busy = 0.
  - mem_funct3 = 3'b010.
  - all address, data and rdata outputs = 0.
  - starve count = 0; state = IDLE.
- States:
  - IDLE: arbitrates only here; samples requests.
  - ACCESS: gnt high one cycle.
  - WAIT: counts READ_LATENCY.
  - RESP: rvalid high one cycle.
- Timing, for a request seen in IDLE in cycle N:
  - Edge ending N → ACCESS. Winner's gnt=1. mem_read_address or mem_write_address = winner address.
  - mem_funct3 = 3'b010 for I, d_funct3 for D.
  - Store: mem_write_data = d_wdata, mem_write_enable = 1.
- Store: ACCESS lasts cycle N+1 only. Then back to IDLE: mem_write_enable = 0, mem_write_address = 0, mem_funct3 = 3'b010. No rvalid.
- Load or fetch:
  - ACCESS → WAIT, counter = READ_LATENCY.
  - Counter decrements each cycle in WAIT. At 0, capture mem_read_data into the winner's rdata and go to RESP.
  - Net: rvalid is high in cycle N+2+READ_LATENCY. rdata holds until that port's next rvalid.
  - RESP → IDLE next edge. RESP cycle also counts as an IDLE sample point, so back-to-back requests lose no cycle.
  - mem_read_address holds its last value after the transaction.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: D wins unless starve count == MAX_STARVE, in which case I wins.
  - Starve count increments on each D win while if_req=1, saturating at MAX_STARVE. It clears when I is granted.
- Requests and operands are sampled only in IDLE/RESP. Changes while busy are ignored.
- A requester may drop req before gnt without effect.
- req still high after gnt is treated as a new request at the next IDLE/RESP.
- Addresses and data pass through unchanged; no alignment checks.
- Reset mid-transaction: immediate return to reset values. The pending transaction is dropped, no rvalid is issued, and mem_write_enable drops asynchronously.
- Only one of if_gnt/d_gnt and one of if_rvalid/d_rvalid may ever be high in a cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, memory word 0x00500093 → if_gnt in N+1; mem_read_address=0x10, mem_funct3=010; if_rvalid in N+3 with if_rdata=0x00500093.
- Store: d_req, d_we=1, d_funct3=000, d_addr=0x2000, d_wdata=0xAB → d_gnt and mem_write_enable high for exactly cycle N+1 only; mem_write_address=0x2000; no d_rvalid.
- Contention: if_req and d_req (load, 0x40) both high in N → d_gnt at N+1, d_rvalid at N+3; if_gnt at N+4 (sampled in RESP).
- Starvation: hold both requests; D loads back-to-back → after 4 D grants, the 5th grant goes to I; count then resets, next contention grants D.
- Reset mid-load: assert reset during WAIT → busy, mem_write_enable, rvalids = 0 immediately; after release, a fetch completes normally with correct data.
- READ_LATENCY=3: single fetch → if_rvalid in N+5, rdata equals memory contents.
